fft_input_loader: RTL and testbench

Serial-to-parallel frame loader that sits directly upstream of the 16-point butterfly array. It accepts one complex sample per cycle over a valid/ready handshake and stores it at its bit-reversed index. Once a full frame is collected, it presents all 16 real/imag words in parallel and pulses `new_input_flag` to launch the first butterfly layer. A shadow buffer lets the next frame fill while the launched frame stays stable on the outputs.

---
 rtl/fft_input_loader.sv | 128 ++++++++++++
 tb/tb_fft_input_loader.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fft_input_loader.sv
// Serial-to-parallel frame loader for the 16-point butterfly array.
// It places each sample at its (optionally bit-reversed) slot and launches full frames in parallel.
module fft_input_loader #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned LOG2N       = 4,
    parameter int unsigned BIT_REVERSE = 1,
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            in_sof,
    input  logic [DATA_W-1:0]               in_real,
    input  logic [DATA_W-1:0]               in_imag,
    output logic [(2**LOG2N)*DATA_W-1:0]    out_real_flat,
    output logic [(2**LOG2N)*DATA_W-1:0]    out_imag_flat,
    output logic                            new_input_flag,
    output logic [7:0]                      frame_cnt,
    output logic                            err_resync
);

    localparam int unsigned N = 2**LOG2N;
    localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N-1);
    localparam logic [7:0] HOLD_LOAD = (HOLD_CYCLES > 0) ? 8'(HOLD_CYCLES-1) : 8'd0;

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    state_t            state;
    logic [LOG2N-1:0]  wr_idx;
    logic [7:0]        hold_cnt;
    logic [DATA_W-1:0] shadow_real    [N];
    logic [DATA_W-1:0] shadow_imag    [N];
    logic [DATA_W-1:0] shadow_real_nx [N];
    logic [DATA_W-1:0] shadow_imag_nx [N];

    logic             accept;
    logic             resync;
    logic             last;
    logic [LOG2N-1:0] wr_slot;

    function automatic logic [LOG2N-1:0] slot_of(input logic [LOG2N-1:0] k);
        logic [LOG2N-1:0] r;
        r = k;
        if (BIT_REVERSE != 0) begin
            for (int i = 0; i < int'(LOG2N); i++) begin
                r[i] = k[int'(LOG2N)-1-i];
            end
        end
        return r;
    endfunction

    // Ready depends only on registered state; reset forces it low.
    assign in_ready = (state == ST_FILL) && !rst;

    // Shadow contents after this cycle's write, so a launch captures the final sample too.
    always_comb begin
        accept         = in_valid && in_ready;
        resync         = accept && in_sof && (wr_idx != '0);
        last           = accept && !resync && (wr_idx == LAST_IDX);
        wr_slot        = slot_of(resync ? '0 : wr_idx);
        shadow_real_nx = shadow_real;
        shadow_imag_nx = shadow_imag;
        if (accept) begin
            shadow_real_nx[wr_slot] = in_real;
            shadow_imag_nx[wr_slot] = in_imag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_FILL;
            wr_idx         <= '0;
            hold_cnt       <= '0;
            frame_cnt      <= '0;
            err_resync     <= 1'b0;
            new_input_flag <= 1'b0;
            shadow_real    <= '{default: '0};
            shadow_imag    <= '{default: '0};
            out_real_flat  <= '0;
            out_imag_flat  <= '0;
        end else begin
            new_input_flag <= 1'b0;
            shadow_real    <= shadow_real_nx;
            shadow_imag    <= shadow_imag_nx;
            case (state)
                ST_FILL: begin
                    if (resync) begin
                        wr_idx     <= LOG2N'(1);
                        err_resync <= 1'b1;
                    end else if (last) begin
                        wr_idx         <= '0;
                        state          <= ST_LAUNCH;
                        new_input_flag <= 1'b1;
                        for (int j = 0; j < int'(N); j++) begin
                            out_real_flat[j*DATA_W +: DATA_W] <= shadow_real_nx[j];
                            out_imag_flat[j*DATA_W +: DATA_W] <= shadow_imag_nx[j];
                        end
                    end else if (accept) begin
                        wr_idx <= wr_idx + LOG2N'(1);
                    end
                end
                ST_LAUNCH: begin
                    frame_cnt <= frame_cnt + 8'd1;
                    if (HOLD_CYCLES > 0) begin
                        state    <= ST_HOLD;
                        hold_cnt <= HOLD_LOAD;
                    end else begin
                        state <= ST_FILL;
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt == 8'd0) begin
                        state <= ST_FILL;
                    end else begin
                        hold_cnt <= hold_cnt - 8'd1;
                    end
                end
                default: state <= ST_FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_input_loader.sv
// Directed bench for fft_input_loader: bit-reversed and natural-order instances share one stimulus stream.
module tb_fft_input_loader;

    localparam int unsigned DW = 16;
    localparam int unsigned N  = 16;
    localparam int unsigned FW = N*DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_sof;
    logic [DW-1:0] in_real;
    logic [DW-1:0] in_imag;

    logic          rdy_br, rdy_nat, flag_br, flag_nat, err_br, err_nat;
    logic [7:0]    fc_br, fc_nat;
    logic [FW-1:0] re_br, im_br, re_nat, im_nat;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fft_input_loader #(.DATA_W(16), .LOG2N(4), .BIT_REVERSE(1), .HOLD_CYCLES(4)) dut_br (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_br), .in_sof(in_sof),
        .in_real(in_real), .in_imag(in_imag), .out_real_flat(re_br), .out_imag_flat(im_br),
        .new_input_flag(flag_br), .frame_cnt(fc_br), .err_resync(err_br)
    );

    fft_input_loader #(.DATA_W(16), .LOG2N(4), .BIT_REVERSE(0), .HOLD_CYCLES(4)) dut_nat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_nat), .in_sof(in_sof),
        .in_real(in_real), .in_imag(in_imag), .out_real_flat(re_nat), .out_imag_flat(im_nat),
        .new_input_flag(flag_nat), .frame_cnt(fc_nat), .err_resync(err_nat)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] brev4(input logic [3:0] k);
        return {k[0], k[1], k[2], k[3]};
    endfunction

    // Expected frame: sample k carries base+k and lands in slot k or bitrev(k).
    function automatic logic [FW-1:0] frame_flat(input logic [DW-1:0] base, input bit rev);
        logic [FW-1:0] f;
        logic [3:0]    s;
        f = '0;
        for (int k = 0; k < int'(N); k++) begin
            s = rev ? brev4(4'(k)) : 4'(k);
            f[int'(s)*DW +: DW] = base + DW'(k);
        end
        return f;
    endfunction

    task automatic apply_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_real  = '0;
        in_imag  = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        in_valid = 1'b1;
        in_sof   = 1'b1;
        in_real  = 16'hABCD;
        in_imag  = 16'h1234;
        tick();
        tick();
        vectors++; if (rdy_br !== 1'b0) begin miscompares++; $display("FAIL reset_ready_low: got %b want 0", rdy_br); end
        vectors++; if (flag_br !== 1'b0) begin miscompares++; $display("FAIL reset_flag: got %b want 0", flag_br); end
        vectors++; if (re_br !== '0 || im_br !== '0) begin miscompares++; $display("FAIL reset_outputs: got %h / %h want 0", re_br, im_br); end
        vectors++; if (fc_br !== 8'd0) begin miscompares++; $display("FAIL reset_frame_cnt: got %0d want 0", fc_br); end
        vectors++; if (err_br !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", err_br); end
        rst      = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        #1;
        vectors++; if (rdy_br !== 1'b1) begin miscompares++; $display("FAIL reset_ready_after: got %b want 1", rdy_br); end
    endtask

    task automatic test_bitrev();
        apply_reset();
        for (int cyc = 1; cyc <= 18; cyc++) begin
            in_valid = (cyc <= 16);
            in_sof   = (cyc == 1);
            in_real  = DW'(cyc-1);
            in_imag  = DW'(16'h100 + cyc - 1);
            vectors++; if (flag_br !== (cyc == 17)) begin miscompares++; $display("FAIL bitrev_flag cyc %0d: got %b want %b", cyc, flag_br, (cyc == 17)); end
            if (cyc <= 16) begin
                vectors++; if (rdy_br !== 1'b1) begin miscompares++; $display("FAIL bitrev_ready cyc %0d: got %b want 1", cyc, rdy_br); end
            end
            if (cyc == 17) begin
                vectors++; if (re_br !== frame_flat(16'h0, 1'b1)) begin miscompares++; $display("FAIL bitrev_real: got %h want %h", re_br, frame_flat(16'h0, 1'b1)); end
                vectors++; if (im_br !== frame_flat(16'h100, 1'b1)) begin miscompares++; $display("FAIL bitrev_imag: got %h want %h", im_br, frame_flat(16'h100, 1'b1)); end
                vectors++; if (re_nat !== frame_flat(16'h0, 1'b0)) begin miscompares++; $display("FAIL natural_real: got %h want %h", re_nat, frame_flat(16'h0, 1'b0)); end
            end
            tick();
        end
        vectors++; if (re_br[1*DW +: DW] !== 16'd8 || im_br[1*DW +: DW] !== 16'h108) begin miscompares++; $display("FAIL bitrev_slot1: got %h/%h want 0008/0108", re_br[1*DW +: DW], im_br[1*DW +: DW]); end
        vectors++; if (re_br[8*DW +: DW] !== 16'd1 || im_br[8*DW +: DW] !== 16'h101) begin miscompares++; $display("FAIL bitrev_slot8: got %h/%h want 0001/0101", re_br[8*DW +: DW], im_br[8*DW +: DW]); end
        vectors++; if (re_br[15*DW +: DW] !== 16'd15) begin miscompares++; $display("FAIL bitrev_slot15: got %h want 000f", re_br[15*DW +: DW]); end
        vectors++; if (fc_br !== 8'd1) begin miscompares++; $display("FAIL bitrev_frame_cnt: got %0d want 1", fc_br); end
    endtask

    task automatic test_back_to_back();
        int  n;
        bit  exp_rdy;
        apply_reset();
        n = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            exp_rdy  = (cyc <= 16) || (cyc >= 22 && cyc <= 37);
            in_valid = (n < 32);
            in_real  = (n < 16) ? DW'(n) : DW'(16'h20 + n - 16);
            in_imag  = DW'(16'h200) + in_real;
            vectors++; if (rdy_nat !== exp_rdy) begin miscompares++; $display("FAIL b2b_ready cyc %0d: got %b want %b", cyc, rdy_nat, exp_rdy); end
            vectors++; if (flag_nat !== (cyc == 17 || cyc == 38)) begin miscompares++; $display("FAIL b2b_flag cyc %0d: got %b want %b", cyc, flag_nat, (cyc == 17 || cyc == 38)); end
            if (cyc >= 17 && cyc < 38) begin
                vectors++; if (re_nat !== frame_flat(16'h0, 1'b0) || im_nat !== frame_flat(16'h200, 1'b0)) begin miscompares++; $display("FAIL b2b_stable cyc %0d: got %h want %h", cyc, re_nat, frame_flat(16'h0, 1'b0)); end
            end
            if (cyc >= 38) begin
                vectors++; if (re_nat !== frame_flat(16'h20, 1'b0) || im_nat !== frame_flat(16'h220, 1'b0)) begin miscompares++; $display("FAIL b2b_frame2 cyc %0d: got %h want %h", cyc, re_nat, frame_flat(16'h20, 1'b0)); end
            end
            if (cyc == 30) begin
                vectors++; if (fc_nat !== 8'd1) begin miscompares++; $display("FAIL b2b_cnt_mid: got %0d want 1", fc_nat); end
            end
            if (in_valid && exp_rdy) n++;
            tick();
        end
        vectors++; if (fc_nat !== 8'd2) begin miscompares++; $display("FAIL b2b_frame_cnt: got %0d want 2", fc_nat); end
    endtask

    task automatic test_resync();
        int i;
        apply_reset();
        i = 0;
        for (int cyc = 1; cyc <= 24; cyc++) begin
            in_valid = (i < 21);
            in_real  = DW'(16'h40 + i + 1);
            in_imag  = DW'(16'h1000) + in_real;
            in_sof   = (i == 0) || (i == 5);
            vectors++; if (err_br !== (cyc >= 7)) begin miscompares++; $display("FAIL resync_err cyc %0d: got %b want %b", cyc, err_br, (cyc >= 7)); end
            vectors++; if (flag_br !== (cyc == 22)) begin miscompares++; $display("FAIL resync_flag cyc %0d: got %b want %b", cyc, flag_br, (cyc == 22)); end
            if (cyc == 22) begin
                vectors++; if (re_br !== frame_flat(16'h46, 1'b1) || im_br !== frame_flat(16'h1046, 1'b1)) begin miscompares++; $display("FAIL resync_data: got %h want %h", re_br, frame_flat(16'h46, 1'b1)); end
            end
            if (in_valid) i++;
            tick();
        end
        in_sof = 1'b0;
    endtask

    task automatic test_reset_midfill();
        int n;
        int flags;
        apply_reset();
        n = 0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            in_valid = (n < 25);
            in_real  = DW'(16'h80 + n);
            in_imag  = DW'(16'h80 + n);
            if (in_valid && ((cyc <= 16) || (cyc >= 22))) n++;
            tick();
        end
        vectors++; if (re_br !== frame_flat(16'h80, 1'b1)) begin miscompares++; $display("FAIL midfill_prior: got %h want %h", re_br, frame_flat(16'h80, 1'b1)); end
        rst     = 1'b1;
        in_real = 16'hEEEE;
        tick();
        vectors++; if (re_br !== '0 || im_br !== '0) begin miscompares++; $display("FAIL midfill_cleared: got %h / %h want 0", re_br, im_br); end
        vectors++; if (fc_br !== 8'd0 || rdy_br !== 1'b0) begin miscompares++; $display("FAIL midfill_cnt_ready: got %0d/%b want 0/0", fc_br, rdy_br); end
        rst = 1'b0;
        n = 0;
        flags = 0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            in_valid = (n < 16);
            in_real  = DW'(16'h90 + n);
            in_imag  = DW'(16'h390 + n);
            if (flag_br) flags++;
            if (in_valid) n++;
            tick();
        end
        vectors++; if (flags !== 1) begin miscompares++; $display("FAIL midfill_launches: got %0d want 1", flags); end
        vectors++; if (fc_br !== 8'd1) begin miscompares++; $display("FAIL midfill_frame_cnt: got %0d want 1", fc_br); end
        vectors++; if (re_br !== frame_flat(16'h90, 1'b1) || im_br !== frame_flat(16'h390, 1'b1)) begin miscompares++; $display("FAIL midfill_data: got %h want %h", re_br, frame_flat(16'h90, 1'b1)); end
    endtask

    task automatic test_gapped();
        int k;
        int flags;
        int last_acc;
        apply_reset();
        k = 0;
        flags = 0;
        last_acc = -10;
        for (int cyc = 1; cyc <= 150; cyc++) begin
            in_valid = (k < 16) ? 1'($urandom_range(0, 1)) : 1'b0;
            in_real  = DW'(k);
            in_imag  = DW'(16'h100 + k);
            if (flag_br) begin
                flags++;
                vectors++; if (cyc !== last_acc + 1) begin miscompares++; $display("FAIL gapped_latency: got cyc %0d want %0d", cyc, last_acc + 1); end
            end
            if (in_valid) begin
                vectors++; if (rdy_br !== 1'b1) begin miscompares++; $display("FAIL gapped_ready cyc %0d: got %b want 1", cyc, rdy_br); end
                k++;
                if (k == 16) last_acc = cyc;
            end
            tick();
        end
        vectors++; if (k !== 16) begin miscompares++; $display("FAIL gapped_budget: got %0d accepts want 16", k); end
        vectors++; if (flags !== 1) begin miscompares++; $display("FAIL gapped_flags: got %0d want 1", flags); end
        vectors++; if (re_br !== frame_flat(16'h0, 1'b1) || im_br !== frame_flat(16'h100, 1'b1)) begin miscompares++; $display("FAIL gapped_data: got %h want %h", re_br, frame_flat(16'h0, 1'b1)); end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_real  = '0;
        in_imag  = '0;
        test_reset();
        test_bitrev();
        test_back_to_back();
        test_resync();
        test_reset_midfill();
        test_gapped();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
